seq_normalizer: RTL

Iterative normalizer. Accepts a word and shifts it one bit per clock, left or right, until the target end bit is 1. Returns the normalized word and the shift count. It is the companion to the combinational barrel shifter: shifting `data_out` by `shift_amt` in the opposite direction, without rotate, restores the original `data_in`. Sits between a producer and a consumer, with valid/ready handshakes on both sides.

---
 rtl/norm_pkg.sv | 11 +
 rtl/seq_normalizer_if.sv | 21 ++
 rtl/norm_step.sv | 17 +
 rtl/seq_normalizer.sv | 72 +++++++
 4 files changed

// File: rtl/norm_pkg.sv
// norm_pkg: state encodings and shift-direction constants shared by the
// normalizer and the barrel shifter.
package norm_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/seq_normalizer_if.sv
// seq_normalizer_if: producer/consumer valid-ready bundle for the normalizer.
interface seq_normalizer_if #(parameter int WIDTH = 4);
    localparam int AMT_W = $clog2(WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic [AMT_W-1:0] shift_amt;
    logic             zero;
    modport master (
        output in_valid, data_in, dir, out_ready,
        input  in_ready, out_valid, data_out, shift_amt, zero
    );
    modport slave (
        input  in_valid, data_in, dir, out_ready,
        output in_ready, out_valid, data_out, shift_amt, zero
    );
endinterface

// File: rtl/norm_step.sv
// norm_step: one combinational normalization step; shifted word plus
// target-bit and all-zero flags.
module norm_step
    import norm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] w,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt,
    output logic             hit,
    output logic             is_zero
);
    assign nxt     = (dir == DIR_LEFT) ? (w << 1) : (w >> 1);
    assign hit     = (dir == DIR_LEFT) ? w[WIDTH-1] : w[0];
    assign is_zero = (w == '0);
endmodule

// File: rtl/seq_normalizer.sv
// seq_normalizer: iterative 1-bit-per-clock normalizer with valid/ready on
// both sides; reports the normalized word, shift count and zero flag.
module seq_normalizer
    import norm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_normalizer_if.slave    bus
);
    localparam int AMT_W = $clog2(WIDTH);

    state_t           state, nxt_state;
    logic [WIDTH-1:0] w, nxt;
    logic [AMT_W-1:0] c;
    logic             dir_q, zero_q, hit, is_zero;

    norm_step #(.WIDTH(WIDTH)) u_step (
        .w       (w),
        .dir     (dir_q),
        .nxt     (nxt),
        .hit     (hit),
        .is_zero (is_zero)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt_state;

    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE:  nxt_state = bus.in_valid ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: nxt_state = (is_zero || hit) ? ST_DONE : ST_SHIFT;
            ST_DONE:  nxt_state = bus.out_ready ? ST_IDLE : ST_DONE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w      <= '0;
            c      <= '0;
            dir_q  <= DIR_RIGHT;
            zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    w      <= bus.data_in;
                    dir_q  <= bus.dir;
                    c      <= '0;
                    zero_q <= 1'b0;
                end
                ST_SHIFT: if (is_zero) begin
                    zero_q <= 1'b1;
                    c      <= '0;
                end else if (!hit) begin
                    w <= nxt;
                    c <= c + AMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.data_out  = w;
    assign bus.shift_amt = c;
    assign bus.zero      = zero_q;
endmodule
